// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared LSU encodings: access kinds, FSM states, error codes
// Purpose: single home for every encoding the LSU and its bench agree on.
// Ports: none (package).
package lsu_pkg;

  // Access kind carried from EX on in_mem_sel.
  typedef enum logic [2:0] {
    NOT_MEM = 3'd0,
    MEM_B   = 3'd1,
    MEM_BU  = 3'd2,
    MEM_H   = 3'd3,
    MEM_HU  = 3'd4,
    MEM_W   = 3'd5
  } mem_sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_HOLD = 2'd3
  } lsu_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // Codes 6/7 are unused and are treated like NOT_MEM (result pass-through).
  function automatic logic is_mem(input logic [2:0] sel);
    return (sel == MEM_B) || (sel == MEM_BU) || (sel == MEM_H) ||
           (sel == MEM_HU) || (sel == MEM_W);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] lo);
    logic r;
    r = 1'b0;
    if ((sel == MEM_H) || (sel == MEM_HU)) r = lo[0];
    if (sel == MEM_W)                      r = (lo != 2'b00);
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane steering for stores and loads
// Purpose: builds store byte enables / lane-replicated data and extracts
//          plus extends load data from a little-endian 32-bit word.
// Ports:
//   mem_sel_i  [2:0]  access kind (lsu_pkg::mem_sel_e encoding)
//   addr_lo_i  [1:0]  byte offset within the word
//   wdata_i    [31:0] right-aligned store data
//   rdata_i    [31:0] raw bus read word
//   be_o       [3:0]  store byte enables
//   wdata_o    [31:0] lane-replicated store data
//   ldata_o    [31:0] extracted, extended load value
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  mem_sel_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      2'd3:    byte_v = rdata_i[31:24];
      default: byte_v = rdata_i[7:0];
    endcase
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    ldata_o = rdata_i;
    case (mem_sel_i)
      MEM_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        ldata_o = {{24{byte_v[7]}}, byte_v};
      end
      MEM_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        ldata_o = {24'h0, byte_v};
      end
      MEM_H: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        ldata_o = {{16{half_v[15]}}, half_v};
      end
      MEM_HU: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        ldata_o = {16'h0, half_v};
      end
      MEM_W: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        ldata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit between EX and WB with a simple req/gnt data bus
// Purpose: accepts one EX result at a time, performs the data-bus access
//          (or passes ALU results through) and holds the write-back result
//          until WB takes it. Misaligned accesses and bus timeouts complete
//          with an error code instead of a bus access.
// Ports:
//   clk, resetn                         clock, async active-low reset
//   in_valid/in_ready                   EX handshake
//   in_mem_sel, in_store, in_addr,
//   in_wdata, in_result, in_wreg        EX payload
//   out_valid/out_ready                 WB handshake
//   out_data, out_wreg, out_err         WB payload (out_wreg=0 means no write)
//   dbus_req, dbus_we, dbus_addr,
//   dbus_be, dbus_wdata                 bus request (held until dbus_gnt)
//   dbus_gnt, dbus_rvalid, dbus_rdata   bus grant and response
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_mem_sel,
  input  logic        in_store,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_result,
  input  logic [4:0]  in_wreg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_wreg,
  output logic [1:0]  out_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  // The counter never exceeds TIMEOUT, so cnt+1 must not wrap at TIMEOUT+1.
  localparam int unsigned CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  lsu_state_e    state_q;
  logic [2:0]    mem_sel_q;
  logic          store_q;
  logic [1:0]    addr_lo_q;
  logic [4:0]    wreg_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic          in_ready_q, out_valid_q, dbus_req_q, dbus_we_q;
  logic [31:0]   out_data_q, dbus_addr_q, dbus_wdata_q;
  logic [4:0]    out_wreg_q;
  logic [1:0]    out_err_q;
  logic [3:0]    dbus_be_q;

  logic [2:0]    al_sel;
  logic [1:0]    al_lo;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata;
  logic [31:0]   al_ldata;
  logic          timeout_hit;

  // One aligner serves both directions: in IDLE it steers the incoming store,
  // in RSP it extracts the load using the registered access kind/offset.
  assign al_sel = (state_q == S_IDLE) ? in_mem_sel      : mem_sel_q;
  assign al_lo  = (state_q == S_IDLE) ? in_addr[1:0]    : addr_lo_q;

  lsu_align u_align (
    .mem_sel_i (al_sel),
    .addr_lo_i (al_lo),
    .wdata_i   (in_wdata),
    .rdata_i   (dbus_rdata),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .ldata_o   (al_ldata)
  );

  assign cnt_d       = cnt_q + CW'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_d >= TO_LIM);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      mem_sel_q    <= NOT_MEM;
      store_q      <= 1'b0;
      addr_lo_q    <= 2'b00;
      wreg_q       <= 5'd0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'h0;
      out_wreg_q   <= 5'd0;
      out_err_q    <= ERR_NONE;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= 32'h0;
      dbus_be_q    <= 4'b0000;
      dbus_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mem_sel_q  <= in_mem_sel;
            store_q    <= in_store;
            addr_lo_q  <= in_addr[1:0];
            wreg_q     <= in_wreg;
            in_ready_q <= 1'b0;
            if (!is_mem(in_mem_sel)) begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
              out_data_q  <= in_result;
              out_wreg_q  <= in_wreg;
              out_err_q   <= ERR_NONE;
            end else if (is_misaligned(in_mem_sel, in_addr[1:0])) begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
              out_data_q  <= 32'h0;
              out_wreg_q  <= 5'd0;
              out_err_q   <= ERR_MISALIGN;
            end else begin
              state_q      <= S_REQ;
              cnt_q        <= '0;
              dbus_req_q   <= 1'b1;
              dbus_we_q    <= in_store;
              dbus_addr_q  <= {in_addr[31:2], 2'b00};
              dbus_be_q    <= al_be;
              dbus_wdata_q <= al_wdata;
            end
          end
        end
        // A grant/response arriving in the last allowed cycle still wins over the abort.
        S_REQ: begin
          cnt_q <= cnt_d;
          if (dbus_gnt) begin
            dbus_req_q <= 1'b0;
            state_q    <= S_RSP;
          end else if (timeout_hit) begin
            dbus_req_q  <= 1'b0;
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= 32'h0;
            out_wreg_q  <= 5'd0;
            out_err_q   <= ERR_TIMEOUT;
          end
        end
        S_RSP: begin
          cnt_q <= cnt_d;
          if (dbus_rvalid) begin
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= store_q ? 32'h0 : al_ldata;
            out_wreg_q  <= store_q ? 5'd0  : wreg_q;
            out_err_q   <= ERR_NONE;
          end else if (timeout_hit) begin
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= 32'h0;
            out_wreg_q  <= 5'd0;
            out_err_q   <= ERR_TIMEOUT;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_wreg   = out_wreg_q;
  assign out_err    = out_err_q;
  assign dbus_req   = dbus_req_q;
  assign dbus_we    = dbus_we_q;
  assign dbus_addr  = dbus_addr_q;
  assign dbus_be    = dbus_be_q;
  assign dbus_wdata = dbus_wdata_q;

endmodule
